t2mi_ts_depacker: RTL and testbench

Receive-side counterpart of the T2-MI-over-TS packer: extracts the T2-MI byte stream carried on one PID from a 188-byte MPEG-TS stream. It parses TS headers, skips adaptation fields, honours the PUSI pointer field to mark T2-MI packet starts, and checks continuity counters. It sits between the TS input interface and the T2-MI packet parser/FIFO.

---
 rtl/t2mi_ts_depacker.sv | 214 +++++++++++++++++++++
 tb/tb_t2mi_ts_depacker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/t2mi_ts_depacker.sv
// T2-MI over MPEG-TS depacker: pulls the T2-MI byte stream carried on one PID out of a
// 188-byte transport stream, tracking continuity and T2-MI packet starts via the pointer field.
module t2mi_ts_depacker (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  DATA_IN,
  input  logic        ENA_IN,
  input  logic        PSYNC_IN,
  input  logic [12:0] t2mi_pid,
  output logic [7:0]  DATA_OUT,
  output logic        ENA_OUT,
  output logic        PSTART_OUT,
  output logic        CC_ERR,
  output logic        FMT_ERR,
  output logic [3:0]  state_mon
);

  localparam int unsigned LAST_POS   = 187;
  localparam int unsigned MAX_AF_LEN = 183;
  localparam logic [7:0]  SYNC_BYTE  = 8'h47;

  typedef enum logic [3:0] {
    S_WAIT_SYNC = 4'd0,
    S_HEADER    = 4'd1,
    S_AF_LEN    = 4'd2,
    S_AF_SKIP   = 4'd3,
    S_POINTER   = 4'd4,
    S_PAYLOAD   = 4'd5,
    S_SKIP      = 4'd6
  } state_t;

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic        tei, tei_n;
  logic        pusi, pusi_n;
  logic [4:0]  pid_hi, pid_hi_n;
  logic [7:0]  pid_lo, pid_lo_n;
  logic [1:0]  afc, afc_n;
  logic [3:0]  last_cc, last_cc_n;
  logic        cc_valid, cc_valid_n;
  logic        lock, lock_n;
  logic [7:0]  af_rem, af_rem_n;
  logic [7:0]  ptr_rem, ptr_rem_n;
  logic        start_pend, start_pend_n;
  logic [7:0]  data_n;
  logic        ena_n, pstart_n, cc_err_n, fmt_err_n;
  logic [7:0]  remain;
  state_t      after_af;

  // State register plus all datapath and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_WAIT_SYNC;
      cnt        <= 8'd0;
      tei        <= 1'b0;
      pusi       <= 1'b0;
      pid_hi     <= 5'd0;
      pid_lo     <= 8'd0;
      afc        <= 2'd0;
      last_cc    <= 4'd0;
      cc_valid   <= 1'b0;
      lock       <= 1'b0;
      af_rem     <= 8'd0;
      ptr_rem    <= 8'd0;
      start_pend <= 1'b0;
      DATA_OUT   <= 8'd0;
      ENA_OUT    <= 1'b0;
      PSTART_OUT <= 1'b0;
      CC_ERR     <= 1'b0;
      FMT_ERR    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      tei        <= tei_n;
      pusi       <= pusi_n;
      pid_hi     <= pid_hi_n;
      pid_lo     <= pid_lo_n;
      afc        <= afc_n;
      last_cc    <= last_cc_n;
      cc_valid   <= cc_valid_n;
      lock       <= lock_n;
      af_rem     <= af_rem_n;
      ptr_rem    <= ptr_rem_n;
      start_pend <= start_pend_n;
      DATA_OUT   <= data_n;
      ENA_OUT    <= ena_n;
      PSTART_OUT <= pstart_n;
      CC_ERR     <= cc_err_n;
      FMT_ERR    <= fmt_err_n;
    end
  end

  assign state_mon = state;

  // Next-state and next-output logic; only ENA_IN-qualified bytes move anything.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    tei_n        = tei;
    pusi_n       = pusi;
    pid_hi_n     = pid_hi;
    pid_lo_n     = pid_lo;
    afc_n        = afc;
    last_cc_n    = last_cc;
    cc_valid_n   = cc_valid;
    lock_n       = lock;
    af_rem_n     = af_rem;
    ptr_rem_n    = ptr_rem;
    start_pend_n = start_pend;
    data_n       = DATA_OUT;
    ena_n        = 1'b0;
    pstart_n     = 1'b0;
    cc_err_n     = 1'b0;
    fmt_err_n    = 1'b0;
    remain       = 8'(LAST_POS) - cnt;
    after_af     = (afc == 2'b10) ? S_SKIP : (pusi ? S_POINTER : S_PAYLOAD);

    if (ENA_IN) begin
      if (PSYNC_IN) begin
        // A sync marker outside wait_sync means the previous packet was short.
        if (state != S_WAIT_SYNC) begin
          fmt_err_n = 1'b1;
          lock_n    = 1'b0;
        end
        if (DATA_IN == SYNC_BYTE) begin
          state_n = S_HEADER;
          cnt_n   = 8'd1;
        end else begin
          fmt_err_n = 1'b1;
          state_n   = S_WAIT_SYNC;
        end
      end else if (state != S_WAIT_SYNC) begin
        cnt_n = cnt + 8'd1;
        case (state)
          S_HEADER: begin
            case (cnt)
              8'd1: begin
                tei_n    = DATA_IN[7];
                pusi_n   = DATA_IN[6];
                pid_hi_n = DATA_IN[4:0];
              end
              8'd2: pid_lo_n = DATA_IN;
              default: begin
                afc_n        = DATA_IN[5:4];
                start_pend_n = 1'b0;
                if (tei || ({pid_hi, pid_lo} != t2mi_pid) || (DATA_IN[5:4] == 2'b00)) begin
                  state_n = S_SKIP;
                end else if (DATA_IN[5:4] == 2'b10) begin
                  state_n = S_AF_LEN;
                end else if (cc_valid && (DATA_IN[3:0] == last_cc)) begin
                  state_n = S_SKIP;
                end else begin
                  if (cc_valid && (DATA_IN[3:0] != last_cc + 4'd1)) begin
                    cc_err_n = 1'b1;
                    lock_n   = 1'b0;
                  end
                  cc_valid_n = 1'b1;
                  last_cc_n  = DATA_IN[3:0];
                  if (DATA_IN[5:4] == 2'b11) state_n = S_AF_LEN;
                  else                       state_n = pusi ? S_POINTER : S_PAYLOAD;
                end
              end
            endcase
          end
          S_AF_LEN: begin
            if (DATA_IN > 8'(MAX_AF_LEN)) begin
              fmt_err_n = 1'b1;
              state_n   = S_SKIP;
            end else if (DATA_IN == 8'd0) begin
              state_n = after_af;
            end else begin
              af_rem_n = DATA_IN;
              state_n  = S_AF_SKIP;
            end
          end
          S_AF_SKIP: begin
            af_rem_n = af_rem - 8'd1;
            if (af_rem == 8'd1) state_n = after_af;
          end
          S_POINTER: begin
            if (DATA_IN >= remain) begin
              fmt_err_n = 1'b1;
              lock_n    = 1'b0;
              state_n   = S_SKIP;
            end else begin
              ptr_rem_n    = DATA_IN;
              start_pend_n = 1'b1;
              state_n      = S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            // Bytes before the pointed-to start continue the previous T2-MI packet.
            if (start_pend && (ptr_rem == 8'd0)) begin
              data_n       = DATA_IN;
              ena_n        = 1'b1;
              pstart_n     = 1'b1;
              lock_n       = 1'b1;
              start_pend_n = 1'b0;
            end else begin
              if (start_pend) ptr_rem_n = ptr_rem - 8'd1;
              if (lock) begin
                data_n = DATA_IN;
                ena_n  = 1'b1;
              end
            end
          end
          default: ;
        endcase
        if (cnt == 8'(LAST_POS)) state_n = S_WAIT_SYNC;
      end
    end
  end

endmodule

// File: tb/tb_t2mi_ts_depacker.sv
// Scoreboard bench for t2mi_ts_depacker: directed TS packets, expected bytes queued by stimulus.
module tb_t2mi_ts_depacker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_in = 8'd0;
  logic        ena_in = 1'b0;
  logic        psync_in = 1'b0;
  logic [12:0] t2mi_pid = 13'h1000;
  logic [7:0]  data_out;
  logic        ena_out, pstart_out, cc_err, fmt_err;
  logic [3:0]  state_mon;

  int n_tests = 0;
  int n_fail  = 0;
  int cc_cnt  = 0;
  int fmt_cnt = 0;
  int cc_base = 0;
  int fmt_base = 0;

  logic [8:0] exp_q[$];
  logic [7:0] pl [0:187];

  t2mi_ts_depacker dut (
    .CLK(clk), .RST(rst), .DATA_IN(data_in), .ENA_IN(ena_in), .PSYNC_IN(psync_in),
    .t2mi_pid(t2mi_pid), .DATA_OUT(data_out), .ENA_OUT(ena_out), .PSTART_OUT(pstart_out),
    .CC_ERR(cc_err), .FMT_ERR(fmt_err), .state_mon(state_mon)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor: counts error pulses and checks every output byte against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (cc_err) cc_cnt++;
      if (fmt_err) fmt_cnt++;
      if (ena_out) begin
        logic [8:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_unexpected: got data %02h pstart %0b, expected no output", data_out, pstart_out);
        end else begin
          e = exp_q.pop_front();
          if ({pstart_out, data_out} !== e) begin
            n_fail++;
            $display("FAIL out_byte: got data %02h pstart %0b, expected data %02h pstart %0b",
                     data_out, pstart_out, e[7:0], e[8]);
          end
        end
      end else if (pstart_out) begin
        n_tests++;
        n_fail++;
        $display("FAIL pstart_alone: PSTART_OUT high without ENA_OUT");
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ps);
    @(negedge clk);
    data_in  = b;
    psync_in = ps;
    ena_in   = 1'b1;
  endtask

  task automatic gap();
    @(negedge clk);
    ena_in   = 1'b0;
    psync_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    ena_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_state", int'(state_mon), 0);
    check("rst_ena", int'(ena_out), 0);
    check("rst_data", int'(data_out), 0);
    check("rst_pstart", int'(pstart_out), 0);
    check("rst_ccerr", int'(cc_err), 0);
    check("rst_fmterr", int'(fmt_err), 0);
    cc_base  = cc_cnt;
    fmt_base = fmt_cnt;
  endtask

  task automatic fill_seq(input int first, input logic [7:0] base);
    for (int p = first; p <= 187; p++) pl[p] = base + 8'(p - first);
  endtask

  task automatic fill_const(input int first, input logic [7:0] v);
    for (int p = first; p <= 187; p++) pl[p] = v;
  endtask

  task automatic push_range(input int first, input int last, input int ps_pos);
    for (int p = first; p <= last; p++) exp_q.push_back({(p == ps_pos), pl[p]});
  endtask

  // Sends header plus pl[4..len-1]; state_mon is checked after byte 100 when exp_mid >= 0.
  task automatic send_pkt(input logic [12:0] pid, input logic tei, input logic pusi,
                          input logic [1:0] afc, input logic [3:0] cc, input int len,
                          input int exp_mid);
    logic [7:0] hdr [0:3];
    hdr[0] = 8'h47;
    hdr[1] = {tei, pusi, 1'b0, pid[12:8]};
    hdr[2] = pid[7:0];
    hdr[3] = {2'b00, afc, cc};
    for (int i = 0; i < len; i++) begin
      if (i == 37 || i == 150) gap();
      if (i == 101) begin
        gap();
        if (exp_mid >= 0) check("state_mid", int'(state_mon), exp_mid);
      end
      send_byte((i < 4) ? hdr[i] : pl[i], (i == 0));
    end
    gap();
  endtask

  task automatic check_phase(input string name, input int exp_cc, input int exp_fmt);
    repeat (4) @(negedge clk);
    check({name, "_ccerr"}, cc_cnt - cc_base, exp_cc);
    check({name, "_fmterr"}, fmt_cnt - fmt_base, exp_fmt);
    check({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    cc_base  = cc_cnt;
    fmt_base = fmt_cnt;
  endtask

  initial begin
    do_reset();

    // Clean PUSI packet, pointer 0.
    pl[4] = 8'd0; fill_seq(5, 8'd0); push_range(5, 187, 5);
    send_pkt(13'h1000, 1'b0, 1'b1, 2'b01, 4'd0, 188, 5);
    check_phase("clean", 0, 0);

    // Packer AF form: AFC=11, AF length 0, PUSI=0.
    pl[4] = 8'd0; fill_const(5, 8'hA5); push_range(5, 187, -1);
    send_pkt(13'h1000, 1'b0, 1'b0, 2'b11, 4'd1, 188, 5);
    check_phase("af_form", 0, 0);

    // Pointer continuation: 10 bytes, then a new T2-MI packet.
    pl[4] = 8'd10; fill_seq(5, 8'h10); push_range(5, 187, 15);
    send_pkt(13'h1000, 1'b0, 1'b1, 2'b01, 4'd2, 188, 5);
    check_phase("ptr_cont", 0, 0);

    // Plain payload packet while locked.
    fill_seq(4, 8'h80); push_range(4, 187, -1);
    send_pkt(13'h1000, 1'b0, 1'b0, 2'b01, 4'd3, 188, 5);
    check_phase("payload", 0, 0);

    // CC sequence after reset: 5 accepted, 7 is an error.
    do_reset();
    pl[4] = 8'd0; fill_seq(5, 8'd0); push_range(5, 187, 5);
    send_pkt(13'h1000, 1'b0, 1'b1, 2'b01, 4'd5, 188, 5);
    check_phase("cc_first", 0, 0);
    fill_seq(4, 8'h30);
    send_pkt(13'h1000, 1'b0, 1'b0, 2'b01, 4'd7, 188, 5);
    check_phase("cc_err", 1, 0);
    send_pkt(13'h1000, 1'b0, 1'b0, 2'b01, 4'd7, 188, 6);
    check_phase("cc_dup", 0, 0);
    send_pkt(13'h1000, 1'b0, 1'b0, 2'b01, 4'd8, 188, 5);
    check_phase("unlocked", 0, 0);
    pl[4] = 8'd3; fill_seq(5, 8'd0); push_range(8, 187, 8);
    send_pkt(13'h1000, 1'b0, 1'b1, 2'b01, 4'd9, 188, 5);
    check_phase("relock", 0, 0);
    fill_seq(4, 8'h55);
    send_pkt(13'h1000, 1'b0, 1'b0, 2'b01, 4'd9, 188, 6);
    check_phase("dup_locked", 0, 0);
    fill_seq(4, 8'h20); push_range(4, 187, -1);
    send_pkt(13'h1000, 1'b0, 1'b0, 2'b01, 4'd10, 188, 5);
    check_phase("after_dup", 0, 0);

    // Filtering: foreign PID and TEI packets.
    send_pkt(13'h1001, 1'b0, 1'b0, 2'b01, 4'd11, 188, 6);
    check_phase("pid_filter", 0, 0);
    send_pkt(13'h1000, 1'b1, 1'b0, 2'b01, 4'd11, 188, 6);
    check_phase("tei_filter", 0, 0);

    // Early sync at byte 100: lock drops, new header parsed.
    fill_seq(4, 8'h40); push_range(4, 99, -1);
    send_pkt(13'h1000, 1'b0, 1'b0, 2'b01, 4'd11, 100, -1);
    fill_seq(4, 8'h60);
    send_pkt(13'h1000, 1'b0, 1'b0, 2'b01, 4'd12, 188, 5);
    check_phase("early_sync", 0, 1);

    // Bad sync byte value.
    send_byte(8'h46, 1'b1);
    gap();
    check("bad_sync_state", int'(state_mon), 0);
    send_byte(8'h47, 1'b0);
    gap();
    check("no_psync_state", int'(state_mon), 0);
    check_phase("bad_sync", 0, 1);

    // Pointer 182 after an empty AF leaves R=182: format error.
    pl[4] = 8'd0; pl[5] = 8'd182; fill_seq(6, 8'd0);
    send_pkt(13'h1000, 1'b0, 1'b1, 2'b11, 4'd13, 188, 6);
    check_phase("ptr_err", 0, 1);

    // Pointer 182 with R=183: start on the final byte.
    pl[4] = 8'd182; fill_seq(5, 8'd0); push_range(187, 187, 187);
    send_pkt(13'h1000, 1'b0, 1'b1, 2'b01, 4'd14, 188, 5);
    check_phase("ptr_max", 0, 0);

    fill_seq(4, 8'h90); push_range(4, 187, -1);
    send_pkt(13'h1000, 1'b0, 1'b0, 2'b01, 4'd15, 188, 5);
    check_phase("cc15", 0, 0);

    // AF length 184 is a format error but keeps lock; CC wraps 15 -> 0.
    pl[4] = 8'd184; fill_seq(5, 8'd0);
    send_pkt(13'h1000, 1'b0, 1'b0, 2'b11, 4'd0, 188, 6);
    check_phase("af_len_err", 0, 1);
    fill_seq(4, 8'hC0); push_range(4, 187, -1);
    send_pkt(13'h1000, 1'b0, 1'b0, 2'b01, 4'd1, 188, 5);
    check_phase("lock_kept", 0, 0);

    // Non-empty AF followed by a pointer.
    pl[4] = 8'd5; fill_const(5, 8'hFF); pl[10] = 8'd2; fill_seq(11, 8'h70);
    push_range(11, 187, 13);
    send_pkt(13'h1000, 1'b0, 1'b1, 2'b11, 4'd2, 188, 5);
    check_phase("af_ptr", 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
